// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: operand select, single-cycle ops and iterative
// one-bit-per-cycle shifts behind a valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_a_src,
    input  logic [1:0]      alu_b_src,
    input  logic [3:0]      alu_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] wrk;
    logic [SW-1:0]   cnt;
    logic [1:0]      sh_op;

    logic [XLEN-1:0] op_a, op_b, alu_res, step;
    logic [SW-1:0]   shamt;
    logic            is_shift, bad;

    assign shamt    = op_b[SW-1:0];
    assign is_shift = (alu_ctrl[3:2] == 2'b10) && (alu_ctrl[1:0] != 2'b11);

    always_comb begin
        op_a = alu_a_src ? pc : rs1_data;
        case (alu_b_src)
            2'b00:   op_b = rs2_data;
            2'b01:   op_b = imm;
            2'b10:   op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    // Shifts only report A here; it is the final value when shamt is zero.
    always_comb begin
        alu_res = '0;
        bad     = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a + op_b;
            4'b1011: alu_res = op_a - op_b;
            4'b0001: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            4'b1000, 4'b1001, 4'b1010: alu_res = op_a;
            default: bad = 1'b1;
        endcase
    end

    // sh_op holds alu_ctrl[1:0]: 00 SLL, 01 SRL, 10 SRA.
    always_comb begin
        case (sh_op)
            2'b00:   step = {wrk[XLEN-2:0], 1'b0};
            2'b01:   step = {1'b0, wrk[XLEN-1:1]};
            default: step = {wrk[XLEN-1], wrk[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wrk     <= '0;
            cnt     <= '0;
            sh_op   <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (is_shift && shamt != '0) begin
                        wrk   <= op_a;
                        cnt   <= shamt;
                        sh_op <= alu_ctrl[1:0];
                        state <= SHIFT;
                    end else begin
                        result  <= alu_res;
                        zero    <= (alu_res == '0);
                        illegal <= bad;
                        state   <= DONE;
                    end
                end
                SHIFT: begin
                    wrk <= step;
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        result  <= step;
                        zero    <= (step == '0);
                        illegal <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed plan cases plus random ops checked
// against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] rs1_data, rs2_data, pc, imm, result;
    logic        alu_a_src, zero, illegal;
    logic [1:0]  alu_b_src;
    logic [3:0]  alu_ctrl;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
        .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'b0000: return {1'b0, a + b};
            4'b1011: return {1'b0, a - b};
            4'b0001: return {1'b0, 31'd0, $signed(a) < $signed(b)};
            4'b0010: return {1'b0, 31'd0, a < b};
            4'b0011: return {1'b0, a ^ b};
            4'b0100: return {1'b0, a | b};
            4'b0111: return {1'b0, a & b};
            4'b1000: return {1'b0, a << sh};
            4'b1001: return {1'b0, a >> sh};
            4'b1010: return {1'b0, 32'($signed(a) >>> sh)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic asrc, input logic [1:0] bsrc,
                          input logic [3:0] ctrl, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] p, input logic [31:0] im);
        logic [31:0] a, b;
        logic [32:0] exp;
        int exp_lat, lat;
        a = asrc ? p : r1;
        case (bsrc)
            2'b00:   b = r2;
            2'b01:   b = im;
            2'b10:   b = 32'd4;
            default: b = 32'd0;
        endcase
        exp = ref_alu(a, b, ctrl);
        exp_lat = (ctrl inside {4'b1000, 4'b1001, 4'b1010}) ? int'(b[4:0]) + 1 : 1;
        rs1_data = r1; rs2_data = r2; pc = p; imm = im;
        alu_a_src = asrc; alu_b_src = bsrc; alu_ctrl = ctrl;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; pc = $urandom; imm = $urandom;
        alu_a_src = 1'($urandom); alu_b_src = 2'($urandom); alu_ctrl = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk({tag, "/busy_in_ready"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/result"}, result, exp[31:0]);
        chk({tag, "/zero"}, {31'd0, zero}, {31'd0, exp[31:0] == 32'd0});
        chk({tag, "/illegal"}, {31'd0, illegal}, {31'd0, exp[32]});
        chk({tag, "/done_in_ready"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/drain_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "/drain_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int hits;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
        alu_a_src = 1'b0; alu_b_src = 2'b00; alu_ctrl = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst/result", result, 32'd0);
        chk("rst/zero", {31'd0, zero}, 32'd0);
        chk("rst/illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        run_op("add",      0, 2'b00, 4'b0000, 32'h5, 32'h3, 0, 0);
        run_op("sub",      0, 2'b00, 4'b1011, 32'h5, 32'h3, 0, 0);
        run_op("sub_neg",  0, 2'b00, 4'b1011, 32'h3, 32'h5, 0, 0);
        run_op("add_wrap", 0, 2'b00, 4'b0000, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op("pc_plus4", 1, 2'b10, 4'b0000, 0, 0, 32'h1000, 0);
        run_op("or_zeroB", 0, 2'b11, 4'b0100, 32'hA5, 32'h1234, 0, 0);
        run_op("add_imm",  0, 2'b01, 4'b0000, 32'h800, 0, 0, 32'hFFFF_F800);
        run_op("sra4",     0, 2'b00, 4'b1010, 32'h8000_0000, 32'h4, 0, 0);
        run_op("srl4",     0, 2'b00, 4'b1001, 32'h8000_0000, 32'h4, 0, 0);
        run_op("sll31",    0, 2'b00, 4'b1000, 32'h1, 32'd31, 0, 0);
        run_op("sll0",     0, 2'b00, 4'b1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_op("srl_b25",  0, 2'b00, 4'b1001, 32'hFFFF_FFFF, 32'h25, 0, 0);
        run_op("slt",      0, 2'b00, 4'b0001, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op("sltu",     0, 2'b00, 4'b0010, 32'hFFFF_FFFF, 32'h1, 0, 0);
        run_op("ill_1100", 0, 2'b00, 4'b1100, 32'h7, 32'h9, 0, 0);

        // Back-pressure: result must hold while out_ready is low.
        rs1_data = 32'hF0F0; rs2_data = 32'h0FF0; alu_a_src = 0; alu_b_src = 2'b00;
        alu_ctrl = 4'b0011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp/first_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            alu_ctrl = 4'b0000; rs1_data = $urandom; rs2_data = $urandom;
            @(posedge clk); #1;
            chk("bp/hold_result", result, 32'hFF00);
            chk("bp/hold_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp/idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp/idle_out_valid", {31'd0, out_valid}, 32'd0);
        run_op("bp_next", 0, 2'b00, 4'b0111, 32'hFF0F, 32'h0FFF, 0, 0);

        // Reset during a long shift discards the op.
        rs1_data = 32'h1; rs2_data = 32'd20; alu_a_src = 0; alu_b_src = 2'b00;
        alu_ctrl = 4'b1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst/in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst/result", result, 32'd0);
        hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk("mrst/no_output", 32'(hits), 32'd0);
        run_op("mrst_add", 0, 2'b00, 4'b0000, 32'h11, 32'h22, 0, 0);

        for (int i = 0; i < 60; i++)
            run_op("rand", 1'($urandom), 2'($urandom), 4'($urandom),
                   $urandom, $urandom, $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
